regbank_rd_arbiter: RTL and testbench
=====================================

Name: regbank_rd_arbiter

Overview:
Shares the single 32-bit read port of the 16-entry register bank among NREQ requesters, such as operand fetch A/B, the debug port and the store-data path. The block does round-robin arbitration and drives the bank read-mux select from the winner's address. It registers the returned word, with write-through forwarding from the bank write port. A winner may hold the port for a bounded burst through a lock request.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width
AW, 4, register address width (bank depth 2^AW)
BURST_MAX, 4, maximum consecutive cycles one locked owner may hold the port (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester read request; held until granted
lock  in  NREQ  per-requester burst request; sampled only with req
addr  in  NREQ*AW  packed read addresses; requester i uses bits [i*AW +: AW]
hold  in  1  datapath owns the port this cycle; no grant
gnt  out  NREQ  one-hot combinational grant, same cycle as selection
mux_sel  out  AW  select to the bank read mux (combinational, winner's addr)
mux_data  in  DW  bank read-mux output (combinational return)
wr_en  in  1  bank write enable (bank writes on this clock edge)
wr_addr  in  AW  bank write address
wr_data  in  DW  bank write data
rd_data  out  DW  registered read data
rd_valid  out  NREQ  one-hot registered valid; bit i = data belongs to requester i

Behaviour:
- Reset (rst_n low, asynchronous) clears all state:
  - rd_data=0, rd_valid=0, ptr=0, state=ARB, owner=0, burst_cnt=0.
  - gnt is forced to 0 and mux_sel to 0 while rst_n is low.
- The round-robin pointer ptr (log2 NREQ bits) names the highest-priority requester. Priority order is ptr, ptr+1, ..., wrapping modulo NREQ.
- State ARB:
  - If hold=1 or req=0: gnt=0 and mux_sel=0; no state change.
  - Otherwise gnt = first set req bit in priority order, and mux_sel = that requester's addr.
  - On the edge: ptr <= winner+1 (mod NREQ).
  - If lock[winner]=1 and BURST_MAX>1: state <= LOCKED, owner <= winner, burst_cnt <= 1.
- State LOCKED:
  - If req[owner]=1 and lock[owner]=1 and hold=0:
    - gnt = one-hot owner, mux_sel = addr[owner], burst_cnt += 1; other requesters are ignored.
    - When burst_cnt reaches BURST_MAX after that grant, return to ARB.
  - If req[owner]=0 or lock[owner]=0: no grant this cycle, return to ARB. Arbitration resumes the next cycle.
  - If hold=1: no grant and no burst_cnt change; stay LOCKED.
  - ptr is not updated in LOCKED; it was already advanced at burst start.
- Latency: a grant in cycle T gives rd_data/rd_valid at the clock edge ending T, visible during T+1.
  - rd_valid is a one-cycle pulse; it is 0 in any cycle following a no-grant cycle.
  - rd_data holds its last value when there is no grant.
- Forwarding: if a grant is issued and wr_en=1 and wr_addr==mux_sel in the same cycle, rd_data <= wr_data; otherwise rd_data <= mux_data.
- A requester that deasserts req before its grant is simply dropped; there is no error.
- Reset mid-burst aborts immediately. After reset, ptr=0, so requester 0 has top priority.
- Implementation must be synthesizable with a parameterized priority search; no latches.

Test Plan:
1. Reset, then req=4'b1111 with addr i = i+1 held for 4 cycles, no lock -> gnt sequence 0001, 0010, 0100, 1000. mux_sel sequence 1, 2, 3, 4. rd_valid follows one cycle later with rd_data = bank contents of r1..r4.
2. Only req[2] asserted for 3 cycles -> gnt=0100 every cycle. After req[2] drops, set req=1111 -> first grant goes to requester 3 (ptr=3).
3. lock[1]=1 with req=1111, BURST_MAX=4 -> requester 1 is granted 4 consecutive cycles. Then ARB grants requester 2. Repeat with lock[1] dropped after 2 grants -> a no-grant cycle, then requester 2.
4. Grant on addr 5 while wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF and mux_data=32'h0 -> rd_data=32'hDEADBEEF next cycle. Repeat with wr_addr=6 -> rd_data=32'h0.
5. hold=1 for 2 cycles with req=1111 -> gnt=0 and rd_valid=0. Same test while LOCKED -> burst_cnt frozen, and the burst resumes after hold drops.
6. Assert rst_n=0 asynchronously mid-burst (between clock edges) -> gnt, rd_valid and rd_data go to 0 immediately. After release with req=1010, first grant goes to requester 1.

Source files
------------

// File: rtl/regbank_rd_arbiter.sv
// Round-robin arbiter for the single register-bank read port, with bounded
// locked bursts and write-through forwarding into the registered read data.
//
// state  | meaning
// ARB    | round-robin selection among all requesters each cycle
// LOCKED | owner holds the port until its burst ends, it drops, or BURST_MAX
module regbank_rd_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int AW        = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*AW-1:0]  addr,
  input  logic                hold,
  output logic [NREQ-1:0]     gnt,
  output logic [AW-1:0]       mux_sel,
  input  logic [DW-1:0]       mux_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic [DW-1:0]       rd_data,
  output logic [NREQ-1:0]     rd_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]   addr_a [NREQ];
  logic            found;
  logic [PW-1:0]   win;
  logic            grant;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] gnt_int;
  logic [AW-1:0]   sel_int;

  always_comb begin
    for (int i = 0; i < NREQ; i++) addr_a[i] = addr[i*AW +: AW];
  end

  // Priority search starting at ptr, wrapping without a modulo operator
  always_comb begin
    int            tmp;
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    tmp   = 0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      tmp = int'(ptr_q) + i;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      idx = PW'(tmp);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    gidx    = '0;
    gnt_int = '0;
    sel_int = '0;
    case (state_q)
      ARB: begin
        if (!hold && found) begin
          grant = 1'b1;
          gidx  = win;
          ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          if (lock[win] && (BURST_MAX > 1)) begin
            state_d = LOCKED;
            owner_d = win;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCKED: begin
        // A dropped owner ends the burst even while the datapath holds the port
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d = ARB;
        end else if (!hold) begin
          grant = 1'b1;
          gidx  = owner_q;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(BURST_MAX)) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (grant) begin
      gnt_int[gidx] = 1'b1;
      sel_int       = addr_a[gidx];
    end
  end

  assign gnt     = rst_n ? gnt_int : '0;
  assign mux_sel = rst_n ? sel_int : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rd_valid <= gnt_int;
      if (grant) rd_data <= (wr_en && (wr_addr == sel_int)) ? wr_data : mux_data;
    end
  end

endmodule

// File: tb/tb_regbank_rd_arbiter.sv
// Directed and randomized checks of regbank_rd_arbiter against a
// cycle-level behavioural model of the read-port sharing rules.
module tb_regbank_rd_arbiter;
  localparam int NREQ = 4, DW = 32, AW = 4, BURST_MAX = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0, lock = '0;
  logic [NREQ*AW-1:0]  addr = '0;
  logic                hold = 1'b0;
  logic [NREQ-1:0]     gnt;
  logic [AW-1:0]       mux_sel;
  logic [DW-1:0]       mux_data;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [DW-1:0]       wr_data = '0;
  logic [DW-1:0]       rd_data;
  logic [NREQ-1:0]     rd_valid;

  logic [DW-1:0] bank [16];
  logic          mux_force = 1'b0;

  regbank_rd_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr), .hold(hold),
    .gnt(gnt), .mux_sel(mux_sel), .mux_data(mux_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;
  assign mux_data = mux_force ? '0 : bank[mux_sel];

  int tests = 0, fails = 0;

  int            m_ptr, m_owner, m_cnt;
  bit            m_locked;
  logic [DW-1:0] m_rd_data;
  logic [3:0]    m_rd_valid;
  logic [3:0]    exp_gnt, exp_sel;
  bit            exp_grant;
  int            exp_win;
  logic [31:0]   obs_gnt, obs_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    m_rd_data = '0; m_rd_valid = '0;
  endtask

  task automatic model_comb();
    int c;
    exp_gnt = '0; exp_sel = '0; exp_grant = 0; exp_win = 0;
    if (!m_locked) begin
      if (!hold && req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (!exp_grant && req[c[1:0]]) begin exp_grant = 1; exp_win = c; end
        end
      end
    end else if (req[m_owner[1:0]] && lock[m_owner[1:0]] && !hold) begin
      exp_grant = 1; exp_win = m_owner;
    end
    if (exp_grant) begin
      exp_gnt = 4'(1 << exp_win);
      exp_sel = addr[exp_win*AW +: AW];
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] mv;
    mv = mux_force ? '0 : bank[exp_sel];
    m_rd_valid = exp_gnt;
    if (exp_grant) m_rd_data = (wr_en && wr_addr == exp_sel) ? wr_data : mv;
    if (!m_locked) begin
      if (exp_grant) begin
        m_ptr = (exp_win + 1) % NREQ;
        if (lock[exp_win[1:0]] && BURST_MAX > 1) begin
          m_locked = 1; m_owner = exp_win; m_cnt = 1;
        end
      end
    end else if (!req[m_owner[1:0]] || !lock[m_owner[1:0]]) begin
      m_locked = 0;
    end else if (exp_grant) begin
      m_cnt++;
      if (m_cnt == BURST_MAX) m_locked = 0;
    end
    if (wr_en) bank[wr_addr] = wr_data;
  endtask

  // Entered at posedge+1 with inputs already applied; leaves at next posedge+1
  task automatic cycle(input string tag);
    #3;
    model_comb();
    obs_gnt = 32'(gnt);
    obs_rd  = rd_data;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".mux_sel"}, 32'(mux_sel), 32'(exp_sel));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
    chk({tag, ".rd_data"}, rd_data, m_rd_data);
    @(posedge clk);
    #1;
    model_edge();
  endtask

  logic [31:0] g0;

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = $urandom;
    model_reset();
    #2;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.mux_sel", 32'(mux_sel), 32'h0);
    chk("rst.rd_valid", 32'(rd_valid), 32'h0);
    chk("rst.rd_data", rd_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: plain round robin over all four requesters
    req = 4'b1111;
    addr = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      cycle("t1");
      chk("t1.seq", obs_gnt, 32'(1) << i);
    end
    req = '0;
    cycle("t1.tail");

    // 2: lone requester, then pointer resumes after it
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle("t2");
      chk("t2.lone", obs_gnt, 32'h4);
    end
    req = 4'b1111;
    cycle("t2.next");
    chk("t2.ptr3", obs_gnt, 32'h8);
    req = '0;
    cycle("t2.idle");

    // 3: full burst from requester 1, then an early-dropped burst
    req = 4'b0001;
    cycle("t3.pre");
    req = 4'b1111; lock = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      cycle("t3.burst");
      chk("t3.owner", obs_gnt, 32'h2);
    end
    lock = '0;
    cycle("t3.after");
    chk("t3.after_gnt", obs_gnt, 32'h4);
    req = 4'b0001;
    cycle("t3.pre2");
    req = 4'b1111; lock = 4'b0010;
    cycle("t3.b2a");
    cycle("t3.b2b");
    lock = '0;
    cycle("t3.drop");
    chk("t3.drop_gnt", obs_gnt, 32'h0);
    cycle("t3.resume");
    chk("t3.resume_gnt", obs_gnt, 32'h4);
    req = '0;
    cycle("t3.idle");

    // 4: write-through forwarding
    mux_force = 1'b1;
    req = 4'b0001; addr = {4'd4, 4'd3, 4'd2, 4'd5};
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    cycle("t4.fwd");
    req = '0; wr_en = 1'b0;
    cycle("t4.chk1");
    chk("t4.fwd_data", obs_rd, 32'hDEADBEEF);
    req = 4'b0001; wr_en = 1'b1; wr_addr = 4'd6;
    cycle("t4.nofwd");
    req = '0; wr_en = 1'b0;
    cycle("t4.chk2");
    chk("t4.nofwd_data", obs_rd, 32'h0);
    mux_force = 1'b0;

    // 5: hold in ARB and inside a burst
    req = 4'b1111; hold = 1'b1;
    cycle("t5.hold_a");
    chk("t5.hold_gnt_a", obs_gnt, 32'h0);
    cycle("t5.hold_b");
    chk("t5.hold_gnt_b", obs_gnt, 32'h0);
    hold = 1'b0; lock = 4'b1111;
    cycle("t5.lk1");
    g0 = obs_gnt;
    cycle("t5.lk2");
    chk("t5.lk2_owner", obs_gnt, g0);
    hold = 1'b1;
    cycle("t5.lkhold1");
    cycle("t5.lkhold2");
    chk("t5.lkhold_gnt", obs_gnt, 32'h0);
    hold = 1'b0;
    cycle("t5.lk3");
    chk("t5.lk3_owner", obs_gnt, g0);
    cycle("t5.lk4");
    chk("t5.lk4_owner", obs_gnt, g0);
    cycle("t5.arb");
    lock = '0; req = '0;
    cycle("t5.idle");

    // 6: asynchronous reset in the middle of a burst
    req = 4'b1111; lock = 4'b1111;
    cycle("t6.b1");
    cycle("t6.b2");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.rst_gnt", 32'(gnt), 32'h0);
    chk("t6.rst_valid", 32'(rd_valid), 32'h0);
    chk("t6.rst_data", rd_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 4'b1010; lock = '0;
    cycle("t6.after");
    chk("t6.first", obs_gnt, 32'h2);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      req     = 4'($urandom);
      lock    = 4'($urandom & $urandom);
      hold    = ($urandom_range(0, 4) == 0);
      addr    = 16'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_data = $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
